// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiplier/divider: radix-4 Booth multiply (16 steps),
// non-restoring divide on magnitudes (32 steps), one registered ready pulse per result.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  // mcand holds the multiplicand, or the divisor magnitude during a divide.
  // hi/lo form the product (hi sign-extended to 34 bits) or remainder/quotient.
  logic [31:0] mcand;
  logic [33:0] hi;
  logic [31:0] lo;
  logic        qm1;
  logic        q_neg;
  logic        div_zero;
  logic        div_ovf;

  logic        mul_last;
  logic        div_last;
  logic [33:0] a_ext;
  logic [33:0] booth_add;
  logic [33:0] mul_sum;
  logic [33:0] mul_hi_next;
  logic [31:0] mul_lo_next;
  logic        mul_ovf;
  logic [33:0] r_shift;
  logic [33:0] div_r_next;
  logic [31:0] div_q_next;
  logic [31:0] quotient;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign mul_last = (state == MUL) && (count == 5'd15);
  assign div_last = (state == DIV) && (count == 5'd31);

  always_comb begin
    state_next = state;
    if (ctrl_MULT) begin
      state_next = MUL;
    end else if (ctrl_DIV) begin
      state_next = DIV;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        MUL:     if (mul_last) state_next = DONE;
        DIV:     if (div_last) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Booth digit from {b[2i+1], b[2i], b[2i-1]} selects 0, +-A or +-2A.
  assign a_ext = {{2{mcand[31]}}, mcand};
  always_comb begin
    booth_add = 34'd0;
    case ({lo[1:0], qm1})
      3'b001, 3'b010: booth_add = a_ext;
      3'b011:         booth_add = {a_ext[32:0], 1'b0};
      3'b100:         booth_add = -{a_ext[32:0], 1'b0};
      3'b101, 3'b110: booth_add = -a_ext;
      default:        booth_add = 34'd0;
    endcase
  end

  assign mul_sum     = hi + booth_add;
  assign mul_hi_next = {{2{mul_sum[33]}}, mul_sum[33:2]};
  assign mul_lo_next = {mul_sum[1:0], lo[31:2]};
  assign mul_ovf     = (mul_hi_next[31:0] != {32{mul_lo_next[31]}});

  // Non-restoring step: subtract when the partial remainder is non-negative, else add.
  assign r_shift    = {hi[32:0], lo[31]};
  assign div_r_next = hi[33] ? (r_shift + {2'b00, mcand}) : (r_shift - {2'b00, mcand});
  assign div_q_next = {lo[30:0], ~div_r_next[33]};
  assign quotient   = q_neg ? (~div_q_next + 32'd1) : div_q_next;

  assign mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count          <= 5'd0;
      mcand          <= 32'd0;
      hi             <= 34'd0;
      lo             <= 32'd0;
      qm1            <= 1'b0;
      q_neg          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      busy           <= (state_next == MUL) || (state_next == DIV);
      if (ctrl_MULT) begin
        mcand <= data_operandA;
        hi    <= 34'd0;
        lo    <= data_operandB;
        qm1   <= 1'b0;
        count <= 5'd0;
      end else if (ctrl_DIV) begin
        mcand    <= mag_b;
        hi       <= 34'd0;
        lo       <= mag_a;
        qm1      <= 1'b0;
        count    <= 5'd0;
        q_neg    <= data_operandA[31] ^ data_operandB[31];
        div_zero <= (data_operandB == 32'd0);
        div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      end else if (state == MUL) begin
        hi    <= mul_hi_next;
        lo    <= mul_lo_next;
        qm1   <= lo[1];
        count <= count + 5'd1;
        if (mul_last) begin
          data_result    <= mul_lo_next;
          data_exception <= mul_ovf;
          data_resultRDY <= 1'b1;
        end
      end else if (state == DIV) begin
        hi    <= div_r_next;
        lo    <= div_q_next;
        count <= count + 5'd1;
        if (div_last) begin
          data_resultRDY <= 1'b1;
          if (div_zero) begin
            data_result    <= 32'd0;
            data_exception <= 1'b1;
          end else if (div_ovf) begin
            data_result    <= 32'h8000_0000;
            data_exception <= 1'b1;
          end else begin
            data_result    <= quotient;
            data_exception <= 1'b0;
          end
        end
      end else begin
        count <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed vector table, hand-written restart/back-to-back/reset
// sequences, and random operations checked against an arithmetic reference model.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: plain signed arithmetic.
  function automatic void model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    int     sa, sb, lo_i;
    longint p;
    sa = a;
    sb = b;
    if (!is_div) begin
      p    = longint'(sa) * longint'(sb);
      r    = p[31:0];
      lo_i = p[31:0];
      e    = (p != longint'(lo_i));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = sa / sb;
      e = 1'b0;
    end
  endfunction

  // driver: k counts negedges after start edge S (k=0 is the cycle after S)
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc,
                        output int rdy_at, output int rdy_n, output int busy_n);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = !is_div;
    ctrl_DIV      = is_div;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    rdy_at = -1; rdy_n = 0; busy_n = 0; res = 32'd0; exc = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clock);
      if (busy) busy_n++;
      if (data_resultRDY) begin
        rdy_n++;
        if (rdy_at < 0) begin
          rdy_at = k;
          res    = data_result;
          exc    = data_exception;
        end
      end
    end
  endtask

  task automatic check_op(input string name, input logic is_div, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_exc);
    logic [31:0] res;
    logic        exc;
    int          rdy_at, rdy_n, busy_n;
    run_op(is_div, a, b, res, exc, rdy_at, rdy_n, busy_n);
    check({name, "_result"}, res, exp_res);
    check({name, "_exc"}, 32'(exc), 32'(exp_exc));
    check({name, "_rdy_at"}, rdy_at, is_div ? 32'd32 : 32'd16);
    check({name, "_rdy_n"}, rdy_n, 32'd1);
    check({name, "_busy_n"}, busy_n, is_div ? 32'd32 : 32'd16);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] r1, r2, er;
    logic        e1, ee;
    int          at1, at2, rn;

    vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[2] = '{1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
    vecs[3] = '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[5] = '{1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0};
    vecs[6] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    vecs[7] = '{1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1};
    vecs[8] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[9] = '{1'b1, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0};

    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_exc", 32'(data_exception), 32'd0);
    check("reset_rdy", 32'(data_resultRDY), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      check_op($sformatf("vec%0d", i), vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);

    // restart: divide 1000/10 aborted by multiply 6*7 sampled at edge S+5
    @(negedge clock);
    data_operandA = 32'd1000; data_operandB = 32'd10; ctrl_DIV = 1'b1;
    @(posedge clock);
    at1 = -1; rn = 0; r1 = 32'd0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        rn++;
        if (at1 < 0) begin at1 = k; r1 = data_result; end
      end
      ctrl_DIV = 1'b0;
      ctrl_MULT = (k == 4);
      if (k == 4) begin data_operandA = 32'd6; data_operandB = 32'd7; end
    end
    check("restart_rdy_n", rn, 32'd1);
    check("restart_rdy_at", at1, 32'd21);
    check("restart_result", r1, 32'd42);

    // back-to-back: divide started in the DONE cycle of a multiply
    @(negedge clock);
    data_operandA = 32'd7; data_operandB = 32'hFFFF_FFFD; ctrl_MULT = 1'b1;
    @(posedge clock);
    at1 = -1; at2 = -1; rn = 0; r1 = 32'd0; r2 = 32'd0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      if (data_resultRDY) begin
        rn++;
        if (at1 < 0) begin
          at1 = k; r1 = data_result;
          data_operandA = 32'hFFFF_FF9C; data_operandB = 32'd7; ctrl_DIV = 1'b1;
        end else if (at2 < 0) begin
          at2 = k; r2 = data_result;
        end
      end
    end
    check("b2b_rdy_n", rn, 32'd2);
    check("b2b_first_at", at1, 32'd16);
    check("b2b_first_result", r1, 32'hFFFF_FFEB);
    check("b2b_second_at", at2, 32'd49);
    check("b2b_second_result", r2, 32'hFFFF_FFF2);

    // async reset mid-multiply, between edges
    @(negedge clock);
    data_operandA = 32'd12345; data_operandB = 32'd678; ctrl_MULT = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (8) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("areset_result", data_result, 32'd0);
    check("areset_exc", 32'(data_exception), 32'd0);
    check("areset_rdy", 32'(data_resultRDY), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    rn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) rn++;
    end
    check("areset_no_rdy", rn, 32'd0);
    check_op("after_reset", 1'b0, 32'd3, 32'd4, 32'd12, 1'b0);

    // random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      logic        is_div;
      logic [31:0] a, b;
      is_div = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        1: begin a = $urandom_range(0, 2000) - 1000; b = $urandom_range(0, 60) - 30; end
        2: b = $urandom_range(0, 2) - 1;
        3: b = b >>> $urandom_range(0, 31);
        default: ;
      endcase
      model(is_div, a, b, er, ee);
      check_op($sformatf("rand%0d_%s", i, is_div ? "div" : "mul"), is_div, a, b, er, ee);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
